// File: rtl/alu_entry_controller.sv
// -----------------------------------------------------------------------------
// alu_entry_controller
//
// Purpose:
//   Steps the user through entering operand A, operand B and an opcode from
//   the board switches. Each value is taken on a press of the debounced ENTER
//   button. After the opcode is taken, the block issues a one-cycle alu_start
//   pulse. It then waits a bounded number of cycles for alu_done and holds the
//   outcome for the display until ENTER is pressed again. A CLEAR press aborts
//   from any state.
//
// Ports:
//   Clk          in   rising-edge system clock
//   Reset        in   asynchronous active-low reset
//   btn_enter    in   debounced ENTER level
//   btn_clear    in   debounced CLEAR level
//   sw_data      in   switch value, sampled on an ENTER event
//   alu_result   in   ALU output (2*WIDTH)
//   alu_done     in   ALU result valid
//   opa/opb      out  operand registers
//   opcode       out  opcode register
//   alu_start    out  one-cycle launch pulse
//   result       out  captured ALU result
//   result_valid out  result holds a completed operation
//   timeout_err  out  ALU did not answer within TIMEOUT cycles
//   state        out  S_A=0 S_B=1 S_OP=2 S_EXEC=3 S_SHOW=4
// -----------------------------------------------------------------------------
module alu_entry_controller #(
  parameter int WIDTH   = 4,
  parameter int OP_W    = 3,
  parameter int TIMEOUT = 15,
  parameter int TO_W    = 4
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               btn_enter,
  input  logic               btn_clear,
  input  logic [WIDTH-1:0]   sw_data,
  input  logic [2*WIDTH-1:0] alu_result,
  input  logic               alu_done,
  output logic [WIDTH-1:0]   opa,
  output logic [WIDTH-1:0]   opb,
  output logic [OP_W-1:0]    opcode,
  output logic               alu_start,
  output logic [2*WIDTH-1:0] result,
  output logic               result_valid,
  output logic               timeout_err,
  output logic [2:0]         state
);

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_EXEC = 3'd3,
    S_SHOW = 3'd4
  } state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   opa_q, opa_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [OP_W-1:0]    opcode_q, opcode_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               alu_start_q, alu_start_d;
  logic               result_valid_q, result_valid_d;
  logic               timeout_err_q, timeout_err_d;
  logic [TO_W-1:0]    counter_q, counter_d;
  logic               enter_prev_q, clear_prev_q;

  logic enter_ev;
  logic clear_ev;
  logic do_clear;

  // The button history resets to 1 so that a button still held when reset
  // is released does not look like a fresh press.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q        <= S_A;
      opa_q          <= '0;
      opb_q          <= '0;
      opcode_q       <= '0;
      result_q       <= '0;
      alu_start_q    <= 1'b0;
      result_valid_q <= 1'b0;
      timeout_err_q  <= 1'b0;
      counter_q      <= '0;
      enter_prev_q   <= 1'b1;
      clear_prev_q   <= 1'b1;
    end else begin
      state_q        <= state_d;
      opa_q          <= opa_d;
      opb_q          <= opb_d;
      opcode_q       <= opcode_d;
      result_q       <= result_d;
      alu_start_q    <= alu_start_d;
      result_valid_q <= result_valid_d;
      timeout_err_q  <= timeout_err_d;
      counter_q      <= counter_d;
      enter_prev_q   <= btn_enter;
      clear_prev_q   <= btn_clear;
    end
  end

  always_comb begin
    enter_ev       = btn_enter & ~enter_prev_q;
    clear_ev       = btn_clear & ~clear_prev_q;
    do_clear       = clear_ev;
    state_d        = state_q;
    opa_d          = opa_q;
    opb_d          = opb_q;
    opcode_d       = opcode_q;
    result_d       = result_q;
    alu_start_d    = 1'b0;
    result_valid_d = result_valid_q;
    timeout_err_d  = timeout_err_q;
    counter_d      = counter_q;

    if (!clear_ev) begin
      case (state_q)
        S_A: begin
          if (enter_ev) begin
            opa_d   = sw_data;
            state_d = S_B;
          end
        end
        S_B: begin
          if (enter_ev) begin
            opb_d   = sw_data;
            state_d = S_OP;
          end
        end
        S_OP: begin
          if (enter_ev) begin
            opcode_d    = sw_data[OP_W-1:0];
            alu_start_d = 1'b1;
            counter_d   = '0;
            state_d     = S_EXEC;
          end
        end
        S_EXEC: begin
          // ENTER is ignored here; only the ALU or the timeout moves us on.
          if (alu_done) begin
            result_d       = alu_result;
            result_valid_d = 1'b1;
            counter_d      = '0;
            state_d        = S_SHOW;
          end else if (counter_q == TO_LAST) begin
            timeout_err_d = 1'b1;
            counter_d     = '0;
            state_d       = S_SHOW;
          end else begin
            counter_d = counter_q + TO_W'(1);
          end
        end
        S_SHOW: begin
          if (enter_ev) begin
            result_valid_d = 1'b0;
            timeout_err_d  = 1'b0;
            state_d        = S_A;
          end
        end
        default: do_clear = 1'b1;  // corrupted encoding: recover like CLEAR
      endcase
    end

    if (do_clear) begin
      state_d        = S_A;
      opa_d          = '0;
      opb_d          = '0;
      opcode_d       = '0;
      result_d       = '0;
      alu_start_d    = 1'b0;
      result_valid_d = 1'b0;
      timeout_err_d  = 1'b0;
      counter_d      = '0;
    end
  end

  assign opa          = opa_q;
  assign opb          = opb_q;
  assign opcode       = opcode_q;
  assign alu_start    = alu_start_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign timeout_err  = timeout_err_q;
  assign state        = state_q;

endmodule

// File: tb/tb_alu_entry_controller.sv
// -----------------------------------------------------------------------------
// tb_alu_entry_controller
//
// Directed bench for alu_entry_controller with default parameters
// (WIDTH=4, OP_W=3, TIMEOUT=15). Inputs change 1 time unit after a rising
// edge. Outputs are read at that same point, after the edge has settled.
// -----------------------------------------------------------------------------
module tb_alu_entry_controller;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       btn_enter;
  logic       btn_clear;
  logic [3:0] sw_data;
  logic [7:0] alu_result;
  logic       alu_done;
  logic [3:0] opa;
  logic [3:0] opb;
  logic [2:0] opcode;
  logic       alu_start;
  logic [7:0] result;
  logic       result_valid;
  logic       timeout_err;
  logic [2:0] state;

  int tests_run  = 0;
  int tests_fail = 0;
  int start_cnt  = 0;
  int start_base;

  alu_entry_controller #(.WIDTH(4), .OP_W(3), .TIMEOUT(15), .TO_W(4)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .btn_enter    (btn_enter),
    .btn_clear    (btn_clear),
    .sw_data      (sw_data),
    .alu_result   (alu_result),
    .alu_done     (alu_done),
    .opa          (opa),
    .opb          (opb),
    .opcode       (opcode),
    .alu_start    (alu_start),
    .result       (result),
    .result_valid (result_valid),
    .timeout_err  (timeout_err),
    .state        (state)
  );

  always #5 Clk = ~Clk;

  // Count the cycles in which alu_start is high, sampled mid-cycle.
  always @(negedge Clk) if (alu_start) start_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: %0d", tag, got);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic press_enter(input logic [3:0] sw);
    sw_data   = sw;
    btn_enter = 1'b1;
    tick(1);
    btn_enter = 1'b0;
    tick(1);
  endtask

  task automatic press_clear();
    btn_clear = 1'b1;
    tick(1);
    btn_clear = 1'b0;
    tick(1);
  endtask

  // Enter A and B, then raise ENTER for the opcode and stop at the cycle
  // where alu_start should be high. ENTER is still held on return.
  task automatic enter_to_exec(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
    press_enter(a);
    press_enter(b);
    sw_data   = op;
    btn_enter = 1'b1;
    tick(1);
  endtask

  initial begin
    Reset      = 1'b0;
    btn_enter  = 1'b1;   // held through reset release
    btn_clear  = 1'b0;
    sw_data    = 4'd9;
    alu_result = 8'd0;
    alu_done   = 1'b0;
    tick(3);

    // Reset state
    check("rst_state", state, 0);
    check("rst_opa", opa, 0);
    check("rst_result", result, 0);
    check("rst_flags", {alu_start, result_valid, timeout_err}, 0);

    // 1. ENTER held through reset release: no event.
    Reset = 1'b1;
    tick(20);
    check("t1_state", state, 0);
    check("t1_opa", opa, 0);
    check("t1_start_cnt", start_cnt, 0);
    btn_enter = 1'b0;
    tick(1);

    // 2. Normal operation, ALU answers two cycles after alu_start.
    start_base = start_cnt;
    enter_to_exec(4'd3, 4'd5, 4'd1);
    check("t2_start_hi", alu_start, 1);
    check("t2_state_exec", state, 3);
    check("t2_opa", opa, 3);
    check("t2_opb", opb, 5);
    check("t2_opcode", opcode, 1);
    btn_enter = 1'b0;
    tick(1);
    check("t2_start_lo", alu_start, 0);
    tick(1);
    alu_done   = 1'b1;
    alu_result = 8'd8;
    tick(1);
    alu_done   = 1'b0;
    check("t2_state_show", state, 4);
    check("t2_result", result, 8);
    check("t2_valid", result_valid, 1);
    check("t2_start_pulses", start_cnt - start_base, 1);
    press_enter(4'd0);
    check("t2_back_state", state, 0);
    check("t2_valid_cleared", result_valid, 0);
    check("t2_opa_kept", opa, 3);

    // 3. No alu_done: timeout exactly 15 cycles after alu_start.
    press_clear();
    check("t3_clr_result", result, 0);
    enter_to_exec(4'd3, 4'd5, 4'd1);
    check("t3_start_hi", alu_start, 1);
    btn_enter = 1'b0;
    tick(14);
    check("t3_state_at14", state, 3);
    check("t3_terr_at14", timeout_err, 0);
    tick(1);
    check("t3_state_at15", state, 4);
    check("t3_terr_at15", timeout_err, 1);
    check("t3_result", result, 0);
    check("t3_valid", result_valid, 0);
    press_enter(4'd0);
    check("t3_terr_cleared", timeout_err, 0);
    check("t3_back_state", state, 0);

    // 4. CLEAR one cycle after alu_start, then a late alu_done.
    enter_to_exec(4'd3, 4'd5, 4'd1);
    btn_enter = 1'b0;
    tick(1);
    btn_clear = 1'b1;
    tick(1);
    btn_clear  = 1'b0;
    alu_done   = 1'b1;
    alu_result = 8'd8;
    tick(2);
    alu_done   = 1'b0;
    check("t4_state", state, 0);
    check("t4_ops", {opa, opb, 1'b0, opcode}, 0);
    check("t4_result", result, 0);
    check("t4_valid", result_valid, 0);

    // 5. ENTER and CLEAR rising together in S_B: CLEAR wins.
    press_enter(4'd2);
    check("t5_in_sb", state, 1);
    sw_data   = 4'd9;
    btn_enter = 1'b1;
    btn_clear = 1'b1;
    tick(1);
    btn_enter = 1'b0;
    btn_clear = 1'b0;
    check("t5_state", state, 0);
    check("t5_opa", opa, 0);
    check("t5_opb", opb, 0);
    tick(1);

    // 6. Long ENTER hold gives one event only.
    sw_data   = 4'd7;
    btn_enter = 1'b1;
    tick(100);
    check("t6_opa", opa, 7);
    check("t6_state_hold", state, 1);
    btn_enter = 1'b0;
    tick(1);
    press_enter(4'd6);
    check("t6_state_again", state, 2);
    check("t6_opb", opb, 6);

    // Asynchronous reset mid-sequence clears everything without a clock edge.
    #2 Reset = 1'b0;
    #1;
    check("arst_state", state, 0);
    check("arst_ops", {opa, opb}, 0);
    Reset = 1'b1;
    tick(1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_fail);
    $finish;
  end

  // Safety bound so the run always terminates.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
